// File: rtl/array_ctrl_pkg.sv
// Shared constants and types for the 256x96 masked-array initiator.
package array_ctrl_pkg;

    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 96;
    localparam int MASK_SEG      = 4;
    localparam int RSP_DEPTH_DEF = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [MASK_SEG-1:0] mask;
        logic [DATA_W-1:0]   data;
    } req_t;

endpackage

// File: rtl/array_ctrl_rsp_fifo.sv
// Read-response FIFO; data output is zero while empty so nothing leaks after reset.
module array_ctrl_rsp_fifo
    import array_ctrl_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEF,
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        valid = (count != '0);
        data  = valid ? mem[rd_ptr] : '0;
    end

    // The initiator's read credit must keep a push into a full buffer from ever happening.
    assert property (@(posedge clock) disable iff (!reset_n)
        (push && !pop) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/array_24_ctrl.sv
// Write/read arbiter and response path for the 256x96 single-port masked array.
// Define ARRAY_CTRL_INIT_EN to zero-fill the array after reset before accepting requests.
module array_24_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [MASK_SEG-1:0] wr_mask,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                init_done,
    output logic [ADDR_W-1:0]   RW0_addr,
    output logic                RW0_en,
    output logic                RW0_wmode,
    output logic [MASK_SEG-1:0] RW0_wmask,
    output logic [DATA_W-1:0]   RW0_wdata,
    input  logic [DATA_W-1:0]   RW0_rdata
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef ARRAY_CTRL_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e            state_q, state_d;
    logic              live_q;
    logic [ADDR_W-1:0] init_addr_q;
    logic              rr_rd_q;
    logic              inflight_q;
    logic              rsp_pop, credit_ok, contested, gnt_wr, gnt_rd;
    logic [CNT_W-1:0]  rsp_count;
    req_t              wr_req, rd_req, op_req;

    array_ctrl_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (RW0_rdata),
        .pop       (rsp_pop),
        .valid     (rsp_valid),
        .data      (rsp_data),
        .count     (rsp_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            live_q      <= 1'b0;
            init_addr_q <= '0;
            rr_rd_q     <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            inflight_q <= gnt_rd;
            if (state_q == ST_INIT && live_q) begin
                init_addr_q <= init_addr_q + ADDR_W'(1);
            end
            if (contested) begin
                rr_rd_q <= ~rr_rd_q;
            end
        end
    end

    // Readiness is "would be granted if valid", so it never looks at its own channel's valid.
    always_comb begin
        wr_req    = '{addr: wr_addr, mask: wr_mask, data: wr_data};
        rd_req    = '{addr: rd_addr, mask: '0, data: '0};
        rsp_pop   = rsp_valid && rsp_ready;
        credit_ok = (int'(inflight_q) + int'(rsp_count) - int'(rsp_pop)) < RSP_DEPTH;
        init_done = live_q && (state_q == ST_RUN);
        wr_ready  = init_done && !(rd_valid && credit_ok && rr_rd_q);
        rd_ready  = init_done && credit_ok && !(wr_valid && !rr_rd_q);
        gnt_wr    = wr_valid && wr_ready;
        gnt_rd    = rd_valid && rd_ready;
        contested = init_done && wr_valid && rd_valid && credit_ok;

        state_d   = state_q;
        op_req    = '0;
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        if (state_q == ST_INIT) begin
            if (live_q) begin
                op_req    = '{addr: init_addr_q, mask: '1, data: '0};
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                if (init_addr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
        end else if (gnt_wr) begin
            op_req    = wr_req;
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
        end else if (gnt_rd) begin
            op_req = rd_req;
            RW0_en = 1'b1;
        end
        RW0_addr  = op_req.addr;
        RW0_wmask = op_req.mask;
        RW0_wdata = op_req.data;
    end

endmodule

// File: tb/tb_array_24_ctrl.sv
// Directed bench for array_24_ctrl with a behavioural 256x96 masked macro.
module tb_array_24_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, wr_valid, rd_valid, rsp_ready;
    logic        wr_ready, rd_ready, rsp_valid, init_done;
    logic [7:0]  wr_addr, rd_addr, RW0_addr;
    logic [3:0]  wr_mask, RW0_wmask;
    logic [95:0] wr_data, rsp_data, RW0_wdata, RW0_rdata;
    logic        RW0_en, RW0_wmode;

    int checks = 0;
    int errors = 0;

    logic [95:0] mem [256] = '{default: '1};

    always #5 clock = ~clock;

    array_24_ctrl #(.RSP_DEPTH(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int s = 0; s < 4; s++) begin
                    if (RW0_wmask[s]) mem[RW0_addr][s*24 +: 24] <= RW0_wdata[s*24 +: 24];
                end
            end else begin
                RW0_rdata <= mem[RW0_addr];
            end
        end
    end

    function automatic logic [95:0] pat(input int i);
        return {8'(i), 88'h1234_5678_9ABC_DEF0_1122_33};
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [3:0] m, input logic [95:0] d);
        int n;
        @(negedge clock);
        wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        #1;
        n = 0;
        while (!wr_ready && n < 20) begin @(negedge clock); #1; n++; end
        checks++;
        if (!wr_ready) begin
            errors++;
            $display("FAIL write_accept addr=%h: wr_ready=%b, required 1", a, wr_ready);
        end
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [95:0] d);
        int n;
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = a; rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!rd_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(negedge clock);
        rd_valid = 1'b0;
        #1;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clock); #1; n++; end
        d = rsp_valid ? rsp_data : 'x;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({wr_ready, rd_ready, rsp_valid, init_done, RW0_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {wr_rdy,rd_rdy,rsp_v,init,en}=%b, required 00000",
                     {wr_ready, rd_ready, rsp_valid, init_done, RW0_en});
        end
        checks++;
        if ({RW0_wmode, RW0_wmask, RW0_addr, RW0_wdata, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_bus: wmode=%b mask=%h addr=%h wdata=%h rsp=%h, required all 0",
                     RW0_wmode, RW0_wmask, RW0_addr, RW0_wdata, rsp_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        logic [95:0] d;
`ifdef ARRAY_CTRL_INIT_EN
        int cyc, bad_ready, bad_data;
        @(posedge clock);
        cyc = 0; bad_ready = 0; bad_data = 0;
        while (cyc < 400) begin
            @(posedge clock);
            cyc++;
            #1;
            if (init_done) break;
            if (wr_ready || rd_ready) bad_ready++;
        end
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL init_latency: init_done after %0d cycles, required 256", cyc);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL init_ready: ready seen in %0d sweep cycles, required 0", bad_ready);
        end
        for (int a = 0; a < 256; a++) begin
            do_read(8'(a), d);
            checks++;
            if (d !== '0) begin
                errors++;
                $display("FAIL init_zero addr=%0d: got %h, required 0", a, d);
            end
        end
`else
        @(posedge clock);
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b, required 1 right after reset release", init_done);
        end
        d = '0;
`endif
    endtask

    task automatic test_masked_write();
        logic [95:0] d;
        do_write(8'h10, 4'hF, '0);
        do_write(8'h10, 4'b0101, '1);
        do_read(8'h10, d);
        checks++;
        if (d !== 96'h000000_FFFFFF_000000_FFFFFF) begin
            errors++;
            $display("FAIL masked_write: got %h, required 000000ffffff000000ffffff", d);
        end
    endtask

    task automatic test_latency();
        do_write(8'h11, 4'hF, pat(17));
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 8'h11; rsp_ready = 1'b1;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_issue: rd_ready=%b, required 1", rd_ready);
        end
        @(negedge clock);
        rd_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_t1: rsp_valid=%b at T+1, required 0", rsp_valid);
        end
        @(negedge clock);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== pat(17)) begin
            errors++;
            $display("FAIL lat_t2: rsp_valid=%b data=%h at T+2, required 1 %h", rsp_valid, rsp_data, pat(17));
        end
        @(negedge clock);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_t3: rsp_valid=%b at T+3, required 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [95:0] resp [4];
        logic [95:0] held;
        int issued, got, acc_blocked, en_blocked, unstable;
        for (int i = 0; i < 4; i++) do_write(8'(32 + i), 4'hF, pat(32 + i));
        issued = 0; got = 0; acc_blocked = 0; en_blocked = 0; unstable = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clock);
            rd_valid = (issued < 4); rd_addr = 8'(32 + issued); rsp_ready = (cyc >= 6);
            #1;
            if (cyc >= 2 && cyc < 6 && RW0_en) en_blocked++;
            if (cyc == 3) held = rsp_data;
            if (cyc == 5 && rsp_data !== held) unstable++;
            if (rd_valid && rd_ready) issued++;
            if (cyc == 5) acc_blocked = issued;
            if (rsp_valid && rsp_ready) begin resp[got] = rsp_data; got++; end
        end
        rd_valid = 1'b0;
        checks++;
        if (acc_blocked != 2 || en_blocked != 0) begin
            errors++;
            $display("FAIL bp_credit: accepted=%0d en_cycles=%0d while blocked, required 2 and 0",
                     acc_blocked, en_blocked);
        end
        checks++;
        if (unstable != 0 || held !== pat(32)) begin
            errors++;
            $display("FAIL bp_hold: head=%h unstable=%0d, required %h stable", held, unstable, pat(32));
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_count: %0d responses, required 4", got);
        end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (resp[i] !== pat(32 + i)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h, required %h", i, resp[i], pat(32 + i));
            end
        end
    endtask

    task automatic test_contention();
        logic [5:0]  seq;
        logic [95:0] d;
        int nw, nr, nrsp, bad;
        seq = '0; nw = 0; nr = 0; nrsp = 0; bad = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clock);
            wr_valid = 1'b1; wr_addr = 8'(48 + nw); wr_mask = 4'hF; wr_data = pat(48 + nw);
            rd_valid = 1'b1; rd_addr = 8'h11; rsp_ready = 1'b1;
            #1;
            if (wr_ready == rd_ready) bad++;
            seq = {seq[4:0], wr_ready};
            if (wr_ready) nw++;
            if (rd_ready) nr++;
            if (rsp_valid) begin nrsp++; if (rsp_data !== pat(17)) bad++; end
        end
        @(negedge clock);
        wr_valid = 1'b0; rd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid) begin nrsp++; if (rsp_data !== pat(17)) bad++; end
            @(negedge clock);
        end
        checks++;
        if (seq !== 6'b101010 || bad != 0) begin
            errors++;
            $display("FAIL rr_seq: grants(W=1)=%b bad=%0d, required 101010 and 0", seq, bad);
        end
        checks++;
        if (nw != 3 || nr != 3 || nrsp != 3) begin
            errors++;
            $display("FAIL rr_count: w=%0d r=%0d rsp=%0d, required 3 3 3", nw, nr, nrsp);
        end
        do_read(8'h32, d);
        checks++;
        if (d !== pat(50)) begin
            errors++;
            $display("FAIL rr_write_kept: got %h, required %h", d, pat(50));
        end
    endtask

    task automatic test_hazard_reset();
        logic [95:0] d;
        int seen;
        do_write(8'h50, 4'hF, pat(1));
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 8'h50; rsp_ready = 1'b1;
        @(negedge clock);
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'h50; wr_mask = 4'hF; wr_data = pat(2);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL haz_wr: wr_ready=%b, required 1", wr_ready);
        end
        @(negedge clock);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== pat(1)) begin
            errors++;
            $display("FAIL haz_old: valid=%b data=%h, required 1 %h", rsp_valid, rsp_data, pat(1));
        end
        do_read(8'h50, d);
        checks++;
        if (d !== pat(2)) begin
            errors++;
            $display("FAIL haz_new: got %h, required %h", d, pat(2));
        end
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 8'h50; rsp_ready = 1'b1;
        @(negedge clock);
        rd_valid = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rsp_valid) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_drop: rsp_valid high in %0d cycles, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_masked_write();
        test_latency();
        test_backpressure();
        test_contention();
        test_hazard_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
